// File: rtl/mux2_rr_arbiter_if.sv
// Bundle of the request/grant handshake and the shared 2:1 mux data path.
// The master side belongs to the requesters. The slave side belongs to the arbiter.
interface mux2_rr_arbiter_if #(
  parameter int WIDTH = 1
) ();

  // Requester-driven handshake and data legs
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;

  // Arbiter-driven grants, select and registered mux result
  logic             gnt0;
  logic             gnt1;
  logic             sel;
  logic [WIDTH-1:0] y;
  logic             y_valid;

  modport master (
    output req0,
    output req1,
    output d0,
    output d1,
    input  gnt0,
    input  gnt1,
    input  sel,
    input  y,
    input  y_valid
  );

  modport slave (
    input  req0,
    input  req1,
    input  d0,
    input  d1,
    output gnt0,
    output gnt1,
    output sel,
    output y,
    output y_valid
  );

endinterface : mux2_rr_arbiter_if

// File: rtl/mux2_rr_arbiter.sv
// Round-robin owner of a shared 2:1 mux. Two requesters compete for the path.
// The arbiter grants one requester at a time and drives the mux select.
// It returns the selected leg, registered one cycle later, with a valid flag.
// A grant holder is forced to rotate after MAX_HOLD consecutive cycles,
// but only while the other requester is also waiting.
module mux2_rr_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mux2_rr_arbiter_if.slave   bus
);

  // Hold counter only needs to reach MAX_HOLD-1; keep at least one bit
  localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [HCW-1:0]   hold_q;
  logic [HCW-1:0]   hold_d;
  logic             last_q;
  logic             last_d;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             sel_q;
  logic [WIDTH-1:0] y_q;
  logic             y_valid_q;
  logic             hold_expired_s;

  assign hold_expired_s = (hold_q == HOLD_LAST);

  // Next grant owner: tie-break on last owner, forced rotation on hold expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req0 && bus.req1) begin
          state_d = last_q ? ST_G0 : ST_G1;
        end else if (bus.req0) begin
          state_d = ST_G0;
        end else if (bus.req1) begin
          state_d = ST_G1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_G0: begin
        if (!bus.req0) begin
          state_d = bus.req1 ? ST_G1 : ST_IDLE;
        end else if (bus.req1 && hold_expired_s) begin
          state_d = ST_G1;
        end else begin
          state_d = ST_G0;
        end
      end
      ST_G1: begin
        if (!bus.req1) begin
          state_d = bus.req0 ? ST_G0 : ST_IDLE;
        end else if (bus.req0 && hold_expired_s) begin
          state_d = ST_G0;
        end else begin
          state_d = ST_G1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Hold counter restarts on any ownership change and saturates while owned
  always_comb begin
    hold_d = hold_q;
    if (state_d != state_q) begin
      hold_d = {HCW{1'b0}};
    end else if (state_q == ST_IDLE) begin
      hold_d = {HCW{1'b0}};
    end else if (hold_expired_s) begin
      hold_d = hold_q;
    end else begin
      hold_d = hold_q + {{(HCW-1){1'b0}}, 1'b1};
    end
  end

  // Remember which side was granted most recently; IDLE leaves it untouched
  always_comb begin
    last_d = last_q;
    if ((state_d != state_q) && (state_d == ST_G0)) begin
      last_d = 1'b0;
    end else if ((state_d != state_q) && (state_d == ST_G1)) begin
      last_d = 1'b1;
    end else begin
      last_d = last_q;
    end
  end

  // Grant FSM with grant/select outputs registered alongside the state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      hold_q  <= {HCW{1'b0}};
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      gnt0_q  <= (state_d == ST_G0);
      gnt1_q  <= (state_d == ST_G1);
      sel_q   <= (state_d == ST_G1);
    end
  end

  // Registered mux leg: capture under the current grant, hold the value when idle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      y_q       <= {WIDTH{1'b0}};
      y_valid_q <= 1'b0;
    end else begin
      y_valid_q <= gnt0_q | gnt1_q;
      if (gnt0_q || gnt1_q) begin
        y_q <= sel_q ? bus.d1 : bus.d0;
      end else begin
        y_q <= y_q;
      end
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.sel     = sel_q;
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;

endmodule : mux2_rr_arbiter
